op_unit: RTL and testbench

OP_UNIT -- requirements
Module: op_unit

---
 rtl/op_unit_pkg.sv | 24 ++
 rtl/op_unit_if.sv | 27 ++
 rtl/op_unit_tail_cmp.sv | 24 ++
 rtl/op_unit.sv | 88 ++++++++
 tb/tb_op_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/op_unit_pkg.sv
// Shared ziggurat constants: table size, fixed-point formats and the tail start R.
// Also the path selector used by the sample decode.
package op_unit_pkg;

  localparam int N     = 256;
  localparam int LOG2N = 8;

  // Q3.28 random inputs, Q7.28 samples, Q6.56 squared tail offsets
  localparam int RND_W  = 32;
  localparam int RND_FW = 28;
  localparam int VAL_W  = 36;
  localparam int VAL_FW = 28;
  localparam int PROD_W = 64;

  // 3.6541528853610088 * 2^28 rounded to nearest
  localparam logic signed [VAL_W-1:0] R_Q = 36'sh0_3A77_6904;

  typedef enum logic [1:0] {
    PATH_FAST,
    PATH_TAIL,
    PATH_WEDGE
  } path_e;

endpackage

// File: rtl/op_unit_if.sv
// Sample-decode bus: candidate inputs from the generator, verdict and sample back.
interface op_unit_if #(
  parameter int LOG2N = op_unit_pkg::LOG2N
);
  import op_unit_pkg::*;

  logic [LOG2N-1:0]        rect_idx;
  logic signed [VAL_W-1:0] mult_value;
  logic                    cmp_value;
  logic signed [RND_W-1:0] rand1;
  logic signed [RND_W-1:0] rand2;
  logic                    tail_case;
  logic                    do_while;
  logic                    reject;
  logic signed [VAL_W-1:0] value;

  modport master (
    output rect_idx, mult_value, cmp_value, rand1, rand2,
    input  tail_case, do_while, reject, value
  );

  modport slave (
    input  rect_idx, mult_value, cmp_value, rand1, rand2,
    output tail_case, do_while, reject, value
  );

endinterface

// File: rtl/op_unit_tail_cmp.sv
// Tail acceptance test: retry when x^2 > 2y, both held exactly in Q6.56.
module op_unit_tail_cmp
  import op_unit_pkg::*;
(
  input  logic signed [RND_W-1:0] rand1_i,
  input  logic signed [RND_W-1:0] rand2_i,
  output logic                    do_while_next_o
);

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] y_ext;
  logic signed [PROD_W-1:0] sq;
  logic signed [PROD_W-1:0] two_y;

  assign x_ext = {{(PROD_W-RND_W){rand1_i[RND_W-1]}}, rand1_i};
  assign y_ext = {{(PROD_W-RND_W){rand2_i[RND_W-1]}}, rand2_i};

  // A Q3.28 square needs at most 63 bits, so the 64-bit product never wraps
  assign sq    = x_ext * x_ext;
  assign two_y = y_ext <<< (RND_FW + 1);

  assign do_while_next_o = (sq > two_y);

endmodule

// File: rtl/op_unit.sv
// Ziggurat sample decode: picks fast/tail/wedge handling for one candidate per
// cycle and registers the verdict and the accepted sample.
module op_unit
  import op_unit_pkg::*;
#(
  parameter int N     = op_unit_pkg::N,
  parameter int LOG2N = op_unit_pkg::LOG2N
) (
  input logic       clk,
  input logic       rst,
  op_unit_if.slave  bus
);

  if (N != (1 << LOG2N)) begin : g_bad_size
    $error("op_unit: N must equal 2**LOG2N");
  end

  path_e                   path;
  logic                    tail_retry;
  logic signed [VAL_W-1:0] x_ext;
  logic signed [VAL_W-1:0] x_abs;
  logic signed [VAL_W-1:0] tail_mag;

  logic                    tail_case_d, tail_case_q;
  logic                    do_while_d,  do_while_q;
  logic                    reject_d,    reject_q;
  logic signed [VAL_W-1:0] value_d,     value_q;

  op_unit_tail_cmp u_tail_cmp (
    .rand1_i         (bus.rand1),
    .rand2_i         (bus.rand2),
    .do_while_next_o (tail_retry)
  );

  // Widening before the negate keeps |-8.0| representable
  assign x_ext    = {{(VAL_W-RND_W){bus.rand1[RND_W-1]}}, bus.rand1};
  assign x_abs    = x_ext[VAL_W-1] ? -x_ext : x_ext;
  assign tail_mag = R_Q + x_abs;

  always_comb begin
    if (bus.cmp_value)               path = PATH_FAST;
    else if (bus.rect_idx == '0)     path = PATH_TAIL;
    else                             path = PATH_WEDGE;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    tail_case_d = 1'b0;
    do_while_d  = 1'b0;
    reject_d    = 1'b0;
    value_d     = '0;
    case (path)
      PATH_FAST: value_d = bus.mult_value;
      PATH_TAIL: begin
        tail_case_d = 1'b1;
        do_while_d  = tail_retry;
        if (!tail_retry) value_d = bus.mult_value[VAL_W-1] ? -tail_mag : tail_mag;
      end
      PATH_WEDGE: begin
        if (bus.rand1 >= bus.rand2) reject_d = 1'b1;
        else                        value_d  = bus.mult_value;
      end
      default: ;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all four outputs
  // update together from the same sampled inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_case_q <= 1'b0;
      do_while_q  <= 1'b0;
      reject_q    <= 1'b0;
      value_q     <= '0;
    end else begin
      tail_case_q <= tail_case_d;
      do_while_q  <= do_while_d;
      reject_q    <= reject_d;
      value_q     <= value_d;
    end
  end

  assign bus.tail_case = tail_case_q;
  assign bus.do_while  = do_while_q;
  assign bus.reject    = reject_q;
  assign bus.value     = value_q;

endmodule

// File: tb/tb_op_unit.sv
// Self-checking bench for op_unit: directed ziggurat cases plus random stimulus
// against a plain-arithmetic reference model.
module tb_op_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  op_unit_if #(.LOG2N(8)) bus ();

  op_unit #(.N(256), .LOG2N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     tail;
    bit     dw;
    bit     rej;
    longint val;
  } exp_t;

  // Reference: the rules in plain integer arithmetic on Q-format values.
  function automatic exp_t model(int unsigned rect, bit cmp, longint mult, longint x, longint y);
    exp_t   e;
    longint r_fix;
    longint ax;
    e.tail = 0; e.dw = 0; e.rej = 0; e.val = 0;
    r_fix  = longint'($rtoi(3.6541528853610088 * 268435456.0 + 0.5));
    if (cmp) begin
      e.val = mult;
    end else if (rect == 0) begin
      e.tail = 1;
      if (x * x > y * 536870912) begin
        e.dw = 1;
      end else begin
        ax    = (x < 0) ? -x : x;
        e.val = (mult < 0) ? -(r_fix + ax) : (r_fix + ax);
      end
    end else if (x >= y) begin
      e.rej = 1;
    end else begin
      e.val = mult;
    end
    return e;
  endfunction

  task automatic drive(input int unsigned rect, input bit cmp, input longint mult,
                       input longint x, input longint y);
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    m = mult; a = x; b = y;
    bus.rect_idx   = rect[7:0];
    bus.cmp_value  = cmp;
    bus.mult_value = m[35:0];
    bus.rand1      = a[31:0];
    bus.rand2      = b[31:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(254, 1, 64'sh5_38F5_A36B, 0, 0);
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus.tail_case, bus.do_while, bus.reject} !== 3'b000 || bus.value !== 36'sd0) begin
      n_fail++;
      $display("FAIL reset_state: got t/d/r=%b%b%b value=%0d, want 000 value=0",
               bus.tail_case, bus.do_while, bus.reject, bus.value);
    end
    rst = 1'b0;
    tick();
    e = model(254, 1, 64'sh5_38F5_A36B, 0, 0);
    n_checks++;
    if ({bus.tail_case, bus.do_while, bus.reject} !== {e.tail, e.dw, e.rej} ||
        longint'(bus.value) !== e.val) begin
      n_fail++;
      $display("FAIL first_after_reset: got value=%0d, want %0d", bus.value, e.val);
    end
  endtask

  task automatic test_fast();
    real v;
    drive(254, 1, 64'sh5_38F5_A36B, 32'sh1234_5678, -5);
    tick();
    v = real'(longint'(bus.value)) / 268435456.0;
    n_checks++;
    if ({bus.tail_case, bus.do_while, bus.reject} !== 3'b000 || bus.value !== 36'sh5_38F5_A36B ||
        v < 83.55997029 || v > 83.55997031) begin
      n_fail++;
      $display("FAIL fast_path: got flags=%b%b%b value=%h (%f), want 000 value=538f5a36b",
               bus.tail_case, bus.do_while, bus.reject, bus.value, v);
    end
  endtask

  task automatic test_wedge();
    // rect, x, y, want_reject, want_value
    longint tbl [4][5] = '{
      '{1,   64'sh0F27_049C, 64'sh01E9_357C, 1, 0},
      '{1,   64'sh01E9_357C, 64'sh0F27_049C, 0, 64'sh0_009A_4072},
      '{77,  64'sh0100_0000, 64'sh0100_0000, 1, 0},
      '{255, -64'sh0100_0000, 64'sh0000_0001, 0, 64'sh0_009A_4072}
    };
    for (int i = 0; i < 4; i++) begin
      drive(int'(tbl[i][0]), 0, 64'sh0_009A_4072, tbl[i][1], tbl[i][2]);
      tick();
      n_checks++;
      if ({bus.tail_case, bus.do_while, bus.reject} !== {2'b00, tbl[i][3] != 0} ||
          longint'(bus.value) !== tbl[i][4]) begin
        n_fail++;
        $display("FAIL wedge[%0d]: got flags=%b%b%b value=%h, want reject=%0d value=%h", i,
                 bus.tail_case, bus.do_while, bus.reject, bus.value, tbl[i][3], tbl[i][4]);
      end
    end
  endtask

  task automatic test_tail();
    // mult, x, y, want_do_while, want_value
    longint tbl [6][5] = '{
      '{ 64'sh0_02BD_0915, -64'sh00ED_1555, 64'sh7DDD_3421, 0,  64'sd996441689},
      '{-64'sh0_02BD_0915, -64'sh00ED_1555, 64'sh7DDD_3421, 0, -64'sd996441689},
      '{ 64'sd5, 64'sh2000_0000, 64'sh1000_0000, 1, 0},
      '{ 64'sd5, 64'sh2000_0000, 64'sh2000_0000, 0, 64'sd980904196 + 64'sh2000_0000},
      '{ 64'sd5, 64'sd0, -64'sh0400_0000, 1, 0},
      '{ 64'sd5, -64'sh8000_0000, 64'sh7FFF_FFFF, 1, 0}
    };
    real v;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, tbl[i][0], tbl[i][1], tbl[i][2]);
      tick();
      n_checks++;
      if ({bus.tail_case, bus.do_while, bus.reject} !== {1'b1, tbl[i][3] != 0, 1'b0} ||
          longint'(bus.value) !== tbl[i][4]) begin
        n_fail++;
        $display("FAIL tail[%0d]: got flags=%b%b%b value=%0d, want do_while=%0d value=%0d", i,
                 bus.tail_case, bus.do_while, bus.reject, bus.value, tbl[i][3], tbl[i][4]);
      end
      if (i < 2) begin
        v = real'(longint'(bus.value)) / 268435456.0;
        if (i == 1) v = -v;
        n_checks++;
        if (v < 3.71203455 || v > 3.71203456) begin
          n_fail++;
          $display("FAIL tail_real[%0d]: got %f, want magnitude 3.7120345573", i, v);
        end
      end
    end
  endtask

  task automatic test_priority();
    drive(0, 1, 64'sh0_02BD_0915, 64'sh2000_0000, 64'sh1000_0000);
    tick();
    n_checks++;
    if ({bus.tail_case, bus.do_while, bus.reject} !== 3'b000 || bus.value !== 36'sh0_02BD_0915) begin
      n_fail++;
      $display("FAIL priority: got flags=%b%b%b value=%h, want 000 value=002bd0915",
               bus.tail_case, bus.do_while, bus.reject, bus.value);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int unsigned rect;
    bit          cmp;
    longint      mult, x, y;
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      rect = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255);
      cmp  = ($urandom_range(0, 3) == 0);
      w    = $urandom;
      mult = longint'($signed({w[3:0], 32'($urandom)}));
      w    = $urandom;
      x    = longint'($signed(w)) >>> $urandom_range(0, 8);
      w    = $urandom;
      y    = longint'($signed(w));
      drive(rect, cmp, mult, x, y);
      e = model(rect, cmp, mult, x, y);
      tick();
      n_checks++;
      if ({bus.tail_case, bus.do_while, bus.reject} !== {e.tail, e.dw, e.rej} ||
          longint'(bus.value) !== e.val) begin
        n_fail++;
        $display("FAIL random[%0d]: got flags=%b%b%b value=%0d, want %b%b%b value=%0d", i,
                 bus.tail_case, bus.do_while, bus.reject, bus.value, e.tail, e.dw, e.rej, e.val);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(254, 1, 64'sh5_38F5_A36B, 0, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.tail_case, bus.do_while, bus.reject} !== 3'b000 || bus.value !== 36'sd0) begin
      n_fail++;
      $display("FAIL reset_midstream: got value=%h, want 0", bus.value);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.tail_case, bus.do_while, bus.reject} !== 3'b000 || bus.value !== 36'sh5_38F5_A36B) begin
      n_fail++;
      $display("FAIL resume_after_reset: got value=%h, want 538f5a36b", bus.value);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_fast();
    test_wedge();
    test_tail();
    test_priority();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
